ray_column_scheduler: RTL and testbench

RAY_COLUMN_SCHEDULER -- requirements
Module: ray_column_scheduler

---
 rtl/ray_column_scheduler.sv | 116 +++++++++++
 tb/tb_ray_column_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_column_scheduler.sv
// Frame sweep sequencer: issues one ray per screen column to an external raytracer,
// waits for each hit, and writes the hit cell into a column buffer.
module ray_column_scheduler #(
    parameter int NUM_COLS  = 64,
    parameter int COL_SHIFT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [13:0] player_x,
    input  logic [12:0] player_y,
    input  logic [7:0]  player_angle,
    output logic        rt_start,
    input  logic        rt_done,
    output logic [13:0] rt_x,
    output logic [12:0] rt_y,
    output logic [7:0]  rt_angle,
    input  logic [5:0]  rt_result_x,
    input  logic [4:0]  rt_result_y,
    output logic        col_we,
    output logic [6:0]  col_addr,
    output logic [10:0] col_data,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [6:0] LAST_COL   = 7'(NUM_COLS - 1);
    // Half the angular span, so the sweep is centred on the view angle.
    localparam logic [7:0] ANGLE_BIAS = 8'(NUM_COLS >> (COL_SHIFT + 1));

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t     state_reg;
    logic [6:0] col_reg;
    logic [7:0] angle_reg;

    function automatic logic [7:0] col_angle(input logic [7:0] base, input logic [6:0] col);
        return base + 8'(col >> COL_SHIFT) - ANGLE_BIAS;
    endfunction

    assign col_addr = col_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            col_reg    <= '0;
            angle_reg  <= '0;
            rt_x       <= '0;
            rt_y       <= '0;
            rt_angle   <= '0;
            col_data   <= '0;
            rt_start   <= 1'b0;
            col_we     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rt_start   <= 1'b0;
            col_we     <= 1'b0;
            frame_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (frame_start) begin
                        rt_x      <= player_x;
                        rt_y      <= player_y;
                        angle_reg <= player_angle;
                        col_reg   <= '0;
                        rt_angle  <= col_angle(player_angle, 7'd0);
                        rt_start  <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // col_data doubles as the capture register for the hit cell.
                    if (rt_done) begin
                        col_data  <= {rt_result_x, rt_result_y};
                        col_we    <= 1'b1;
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    if (col_reg == LAST_COL) begin
                        frame_done <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        col_reg   <= col_reg + 7'd1;
                        rt_angle  <= col_angle(angle_reg, col_reg + 7'd1);
                        rt_start  <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    strobes_exclusive: assert property (@(posedge clock) disable iff (reset)
        $onehot0({rt_start, col_we, frame_done}));

endmodule

// File: tb/tb_ray_column_scheduler.sv
// Randomized bench for ray_column_scheduler: a timestamp-based behavioural model
// is compared against the DUT every cycle, plus literal pins on known frames.
module tb_ray_column_scheduler;

    localparam int NC = 64;
    localparam int CS = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic [13:0] player_x = '0;
    logic [12:0] player_y = '0;
    logic [7:0]  player_angle = '0;
    logic        rt_done = 1'b0;
    logic [5:0]  rt_result_x = '0;
    logic [4:0]  rt_result_y = '0;
    logic        rt_start;
    logic [13:0] rt_x;
    logic [12:0] rt_y;
    logic [7:0]  rt_angle;
    logic        col_we;
    logic [6:0]  col_addr;
    logic [10:0] col_data;
    logic        busy;
    logic        frame_done;

    ray_column_scheduler #(.NUM_COLS(NC), .COL_SHIFT(CS)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .player_x(player_x), .player_y(player_y), .player_angle(player_angle),
        .rt_start(rt_start), .rt_done(rt_done),
        .rt_x(rt_x), .rt_y(rt_y), .rt_angle(rt_angle),
        .rt_result_x(rt_result_x), .rt_result_y(rt_result_y),
        .col_we(col_we), .col_addr(col_addr), .col_data(col_data),
        .busy(busy), .frame_done(frame_done)
    );

    initial forever #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;
    int tick = 0;
    always @(posedge clock) tick <= tick + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: events scheduled by absolute cycle number.
    int cyc = 0;
    bit active = 0;
    bit waiting = 0;
    int mcol = 0;
    int lx = 0, ly = 0, la = 0;
    int issue_at = -1, write_at = -1, done_at = -1;
    int cap = 0, last_data = 0;

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            active = 0; waiting = 0; mcol = 0; lx = 0; ly = 0; la = 0;
            issue_at = -1; write_at = -1; done_at = -1; cap = 0; last_data = 0;
        end else begin
            if (!active && frame_start) begin
                active = 1; lx = player_x; ly = player_y; la = player_angle;
                mcol = 0; issue_at = cyc + 1;
            end
            if (cyc == issue_at) waiting = 1;
            else if (waiting && rt_done) begin
                waiting = 0;
                cap = rt_result_x * 32 + rt_result_y;
                write_at = cyc + 1;
            end
            if (cyc == write_at) begin
                last_data = cap;
                if (mcol == NC - 1) done_at = cyc + 1;
                else begin
                    mcol = mcol + 1;
                    issue_at = cyc + 1;
                end
            end
            if (cyc == done_at) active = 0;
            cyc = cyc + 1;
        end
    end

    function automatic int exp_angle();
        return ((la + mcol / (1 << CS) - NC / (1 << (CS + 1))) % 256 + 256) % 256;
    endfunction

    initial forever begin
        @(negedge clock);
        check("busy", busy, active);
        check("rt_start", rt_start, issue_at == cyc);
        check("col_we", col_we, write_at == cyc);
        check("frame_done", frame_done, done_at == cyc);
        check("col_addr", col_addr, mcol);
        check("col_data", col_data, (write_at == cyc) ? cap : last_data);
        check("rt_x", rt_x, lx);
        check("rt_y", rt_y, ly);
        if (issue_at == cyc || waiting) check("rt_angle", rt_angle, exp_angle());
    end

    // Observation monitor feeding the literal pins.
    logic [7:0]  ang_seen [0:127];
    int          writes_frame = 0, we_total = 0, last_writes = 0, frames_seen = 0;
    int          fd_tick = 0, fs_tick = 0;
    logic [10:0] first_we_data = '0;
    logic [6:0]  first_we_addr = '0;
    logic [13:0] last_rtx = '0;

    initial forever begin
        @(negedge clock);
        if (rt_start) begin
            if (col_addr == 7'd0) writes_frame = 0;
            ang_seen[col_addr] = rt_angle;
        end
        if (col_we) begin
            if (writes_frame == 0) begin
                first_we_addr = col_addr;
                first_we_data = col_data;
            end
            writes_frame++;
            we_total++;
        end
        if (frame_done) begin
            fd_tick = tick;
            last_writes = writes_frame;
            last_rtx = rt_x;
            frames_seen++;
        end
    end

    // Raytracer responder; all rt_done/result driving happens here.
    int rt_lat = 5;
    bit lat_rand = 0, fixed_res = 0, stray = 0;
    int spur_req = 0, spur_done = 0;

    initial forever begin
        @(negedge clock);
        if (spur_req != spur_done) begin
            spur_done++;
            rt_done = 1'b1;
            rt_result_x = 6'($urandom);
            rt_result_y = 5'($urandom);
            @(posedge clock); #1;
            rt_done = 1'b0;
        end else if (rt_start) begin
            rt_lat = lat_rand ? int'($urandom_range(0, 6)) : rt_lat;
            if (stray) begin
                rt_done = 1'b1;
                rt_result_x = 6'($urandom);
                rt_result_y = 5'($urandom);
            end
            @(posedge clock); #1;
            rt_done = 1'b0;
            repeat (rt_lat) @(posedge clock);
            #1;
            rt_done = 1'b1;
            rt_result_x = fixed_res ? 6'h2A : 6'($urandom);
            rt_result_y = fixed_res ? 5'h13 : 5'($urandom);
            @(posedge clock); #1;
            rt_done = 1'b0;
        end
    end

    task automatic start_frame(input logic [13:0] x, input logic [12:0] y, input logic [7:0] a);
        @(posedge clock); #1;
        player_x = x; player_y = y; player_angle = a;
        frame_start = 1'b1;
        fs_tick = tick;
        @(posedge clock); #1;
        frame_start = 1'b0;
        @(negedge clock);
        check("first_rt_start_latency", rt_start, 1'b1);
        check("first_col_is_zero", col_addr, 7'd0);
    endtask

    task automatic wait_frame();
        int start = frames_seen;
        for (int i = 0; i < 2000 && frames_seen == start; i++) @(negedge clock);
        check("frame_done_seen", frames_seen - start, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    int we_before;
    logic [13:0] px;

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_busy", busy, 1'b0);
        check("reset_col_addr", col_addr, 7'd0);
        check("reset_col_data", col_data, 11'd0);
        check("reset_rt_x", rt_x, 14'd0);
        check("reset_strobes", {rt_start, col_we, frame_done}, 3'b000);
        @(posedge clock); #1 reset = 1'b0;

        we_before = we_total;
        repeat (3) begin
            spur_req++;
            repeat (4) @(posedge clock);
        end
        check("idle_spurious_writes", we_total - we_before, 0);

        // Known frame: fixed 5-cycle latency and fixed hit cell.
        lat_rand = 0; rt_lat = 5; fixed_res = 1;
        start_frame(14'h1234, 13'h0ABC, 8'h05);
        wait_frame();
        check("angle_col0_wrap", ang_seen[0], 8'hF5);
        check("angle_col1", ang_seen[1], 8'hF5);
        check("angle_col2", ang_seen[2], 8'hF6);
        check("angle_col63", ang_seen[63], 8'h14);
        check("first_col_data", first_we_data, 11'h553);
        check("writes_frame_a", last_writes, 64);
        check("frame_cycles_lat5", fd_tick - fs_tick, 513);
        check("rt_x_frame_a", last_rtx, 14'h1234);

        // Random latencies/results with frame_start and player noise mid-frame.
        fixed_res = 0; lat_rand = 1;
        px = 14'($urandom);
        start_frame(px, 13'($urandom), 8'($urandom));
        for (int i = 0; i < 150; i++) begin
            @(posedge clock); #1;
            frame_start = 1'($urandom_range(0, 1));
            player_x = 14'($urandom);
            player_y = 13'($urandom);
            player_angle = 8'($urandom);
        end
        @(posedge clock); #1 frame_start = 1'b0;
        wait_frame();
        check("writes_frame_b", last_writes, 64);
        check("rt_x_frame_b_held", last_rtx, px);

        // Stray rt_done during every ISSUE, zero raytracer latency.
        lat_rand = 0; rt_lat = 0; stray = 1;
        start_frame(14'($urandom), 13'($urandom), 8'($urandom));
        wait_frame();
        stray = 0;
        check("writes_frame_c", last_writes, 64);
        check("frame_cycles_lat0", fd_tick - fs_tick, 193);

        // Asynchronous reset while waiting on column 2.
        rt_lat = 5;
        start_frame(14'($urandom), 13'($urandom), 8'($urandom));
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (rt_start && col_addr == 7'd2) break;
        end
        check("reached_col2", col_addr, 7'd2);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_col_addr", col_addr, 7'd0);
        check("async_reset_col_data", col_data, 11'd0);
        we_before = we_total;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (12) @(posedge clock);
        check("pending_done_ignored", we_total - we_before, 0);

        // Frame after reset must restart from column 0.
        lat_rand = 1;
        start_frame(14'($urandom), 13'($urandom), 8'($urandom));
        wait_frame();
        check("writes_frame_e", last_writes, 64);
        check("first_write_addr_e", first_we_addr, 7'd0);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
